// File: rtl/pattern_seq_detector.sv
// Runtime-programmable serial pattern detector with overlap control and a saturating hit counter.
// Optional feature macro: SEQDET_COUNT_EN (defined = match_count register present, undefined = tied to 0).
module pattern_seq_detector #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1),
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               data_in,
    input  logic               data_valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    output logic               match,
    output logic [CNT_W-1:0]   match_count,
    output logic               cfg_err,
    output logic               armed
);

    typedef enum logic {
        UNCONFIG = 1'b0,
        HUNT     = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [MAX_LEN-1:0] pattern;
    logic [MAX_LEN-1:0] pattern_next;
    logic [LEN_W-1:0]   len;
    logic [LEN_W-1:0]   len_next;
    logic               overlap;
    logic               overlap_next;
    logic [MAX_LEN-1:0] hist;
    logic [MAX_LEN-1:0] hist_next;
    logic [MAX_LEN-1:0] hist_shift;
    logic [LEN_W-1:0]   fill;
    logic [LEN_W-1:0]   fill_next;
    logic [LEN_W-1:0]   fill_inc;
    logic [MAX_LEN-1:0] len_mask;
    logic               load_ok;
    logic               load_bad;
    logic               sample;
    logic               hit;

    assign load_ok  = cfg_load && (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
    assign load_bad = cfg_load && !load_ok;
    // A load in the same cycle as valid data takes priority and drops that bit.
    assign sample   = (state == HUNT) && data_valid && !cfg_load;

    assign hist_shift = {hist[MAX_LEN-2:0], data_in};
    assign fill_inc   = (fill == LEN_W'(MAX_LEN)) ? fill : fill + 1'b1;

    always_comb begin
        len_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (LEN_W'(i) < len);
        end
    end

    assign hit = sample && (fill_inc >= len) && (((hist_shift ^ pattern) & len_mask) == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= UNCONFIG;
            pattern <= '0;
            len     <= '0;
            overlap <= 1'b0;
            hist    <= '0;
            fill    <= '0;
            match   <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            state   <= state_next;
            pattern <= pattern_next;
            len     <= len_next;
            overlap <= overlap_next;
            hist    <= hist_next;
            fill    <= fill_next;
            match   <= hit;
            cfg_err <= load_bad;
        end
    end

    // Without overlap the fill count restarts after a hit so the next match needs len fresh bits.
    always_comb begin
        state_next   = state;
        pattern_next = pattern;
        len_next     = len;
        overlap_next = overlap;
        hist_next    = hist;
        fill_next    = fill;
        if (load_ok) begin
            state_next   = HUNT;
            pattern_next = cfg_pattern;
            len_next     = cfg_len;
            overlap_next = cfg_overlap;
            hist_next    = '0;
            fill_next    = '0;
        end else if (sample) begin
            hist_next = hist_shift;
            fill_next = (hit && !overlap) ? '0 : fill_inc;
        end
    end

    assign armed = (state == HUNT);

`ifdef SEQDET_COUNT_EN
    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load_ok) begin
            count <= '0;
        end else if (hit && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    assign match_count = count;
`else
    assign match_count = '0;
`endif

endmodule

// File: tb/tb_pattern_seq_detector.sv
// Directed table-driven bench for pattern_seq_detector plus hand-written corner sequences.
module tb_pattern_seq_detector;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);
    localparam int CNT_W   = 2;

    logic               clk;
    logic               reset;
    logic               data_in;
    logic               data_valid;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               match;
    logic [CNT_W-1:0]   match_count;
    logic               cfg_err;
    logic               armed;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic               rst;
        logic               dv;
        logic               din;
        logic               load;
        logic [MAX_LEN-1:0] pat;
        logic [LEN_W-1:0]   len;
        logic               ov;
        logic               exp_match;
        int                 exp_count;
        logic               exp_err;
        logic               exp_armed;
        string              name;
    } vec_t;

    vec_t vecs[$];

    pattern_seq_detector #(
        .MAX_LEN(MAX_LEN),
        .LEN_W  (LEN_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .data_valid (data_valid),
        .cfg_load   (cfg_load),
        .cfg_pattern(cfg_pattern),
        .cfg_len    (cfg_len),
        .cfg_overlap(cfg_overlap),
        .match      (match),
        .match_count(match_count),
        .cfg_err    (cfg_err),
        .armed      (armed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The counter only exists when the optional feature is compiled in.
    function automatic logic [CNT_W-1:0] exp_cnt(input int v);
`ifdef SEQDET_COUNT_EN
        return CNT_W'(v);
`else
        return (v == 0) ? '0 : '0;
`endif
    endfunction

    task automatic add(input logic rst, input logic dv, input logic din, input logic load,
                       input logic [MAX_LEN-1:0] pat, input logic [LEN_W-1:0] len, input logic ov,
                       input logic m, input int c, input logic e, input logic a, input string name);
        vec_t v;
        v.rst = rst; v.dv = dv; v.din = din; v.load = load;
        v.pat = pat; v.len = len; v.ov = ov;
        v.exp_match = m; v.exp_count = c; v.exp_err = e; v.exp_armed = a;
        v.name = name;
        vecs.push_back(v);
    endtask

    task automatic bit_in(input logic dv, input logic din, input logic m, input int c,
                          input logic a, input string name);
        add(1'b0, dv, din, 1'b0, 8'h00, 4'd0, 1'b0, m, c, 1'b0, a, name);
    endtask

    task automatic apply_stimulus(input logic rst, input logic dv, input logic din, input logic load,
                                  input logic [MAX_LEN-1:0] pat, input logic [LEN_W-1:0] len,
                                  input logic ov);
        reset       = rst;
        data_valid  = dv;
        data_in     = din;
        cfg_load    = load;
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ov;
        @(posedge clk);
        #1;
    endtask

    task automatic check_one(input string name, input string field, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s.%s: got %0d, expected %0d", name, field, act, exp);
        end
    endtask

    task automatic check_output(input string name, input logic m, input int c,
                                input logic e, input logic a);
        check_one(name, "match", int'(match), int'(m));
        check_one(name, "match_count", int'(match_count), int'(exp_cnt(c)));
        check_one(name, "cfg_err", int'(cfg_err), int'(e));
        check_one(name, "armed", int'(armed), int'(a));
    endtask

    initial begin
        reset = 1'b1; data_valid = 1'b0; data_in = 1'b0; cfg_load = 1'b0;
        cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;

        add(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 0, 1'b0, 1'b0, "reset");
        bit_in(1'b1, 1'b1, 1'b0, 0, 1'b0, "unconfig_ignore");

        // Pattern 1011, overlapping
        add(1'b0, 1'b0, 1'b0, 1'b1, 8'h0B, 4'd4, 1'b1, 1'b0, 0, 1'b0, 1'b1, "ov_load");
        bit_in(1'b1, 1'b1, 1'b0, 0, 1'b1, "ov_b1");
        bit_in(1'b1, 1'b0, 1'b0, 0, 1'b1, "ov_b2");
        bit_in(1'b1, 1'b1, 1'b0, 0, 1'b1, "ov_b3");
        bit_in(1'b1, 1'b1, 1'b1, 1, 1'b1, "ov_b4");
        bit_in(1'b1, 1'b0, 1'b0, 1, 1'b1, "ov_b5");
        bit_in(1'b1, 1'b1, 1'b0, 1, 1'b1, "ov_b6");
        bit_in(1'b1, 1'b1, 1'b1, 2, 1'b1, "ov_b7");
        bit_in(1'b0, 1'b0, 1'b0, 2, 1'b1, "ov_idle");

        // Same stream, non-overlapping
        add(1'b0, 1'b0, 1'b0, 1'b1, 8'h0B, 4'd4, 1'b0, 1'b0, 0, 1'b0, 1'b1, "nov_load");
        bit_in(1'b1, 1'b1, 1'b0, 0, 1'b1, "nov_b1");
        bit_in(1'b1, 1'b0, 1'b0, 0, 1'b1, "nov_b2");
        bit_in(1'b1, 1'b1, 1'b0, 0, 1'b1, "nov_b3");
        bit_in(1'b1, 1'b1, 1'b1, 1, 1'b1, "nov_b4");
        bit_in(1'b1, 1'b0, 1'b0, 1, 1'b1, "nov_b5");
        bit_in(1'b1, 1'b1, 1'b0, 1, 1'b1, "nov_b6");
        bit_in(1'b1, 1'b1, 1'b0, 1, 1'b1, "nov_b7");

        // Pattern 1111, non-overlapping, with gaps carrying a 1 on data_in
        add(1'b0, 1'b0, 1'b0, 1'b1, 8'h0F, 4'd4, 1'b0, 1'b0, 0, 1'b0, 1'b1, "gap_load");
        for (int i = 1; i <= 8; i++) begin
            bit_in(1'b1, 1'b1, (i == 4 || i == 8), (i >= 8) ? 2 : (i >= 4 ? 1 : 0), 1'b1,
                   $sformatf("gap_v%0d", i));
            bit_in(1'b0, 1'b1, 1'b0, (i >= 8) ? 2 : (i >= 4 ? 1 : 0), 1'b1,
                   $sformatf("gap_g%0d", i));
        end

        // Illegal loads leave configuration and counter untouched
        add(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 4'd0, 1'b1, 1'b0, 2, 1'b1, 1'b1, "bad_len0");
        add(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 4'd9, 1'b1, 1'b0, 2, 1'b1, 1'b1, "bad_len9");
        bit_in(1'b1, 1'b1, 1'b0, 2, 1'b1, "old_b1");
        bit_in(1'b1, 1'b1, 1'b0, 2, 1'b1, "old_b2");
        bit_in(1'b1, 1'b1, 1'b0, 2, 1'b1, "old_b3");
        bit_in(1'b1, 1'b1, 1'b1, 3, 1'b1, "old_b4");

        // len = 1, back-to-back pulses, counter saturates at 3
        add(1'b0, 1'b0, 1'b0, 1'b1, 8'h01, 4'd1, 1'b1, 1'b0, 0, 1'b0, 1'b1, "sat_load");
        for (int i = 1; i <= 5; i++) begin
            bit_in(1'b1, 1'b1, 1'b1, (i > 3) ? 3 : i, 1'b1, $sformatf("sat_b%0d", i));
        end

        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i].rst, vecs[i].dv, vecs[i].din, vecs[i].load,
                           vecs[i].pat, vecs[i].len, vecs[i].ov);
            check_output(vecs[i].name, vecs[i].exp_match, vecs[i].exp_count,
                         vecs[i].exp_err, vecs[i].exp_armed);
        end

        // Reset after 3 of 4 bits; the reset-cycle bit would have completed the pattern
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h0B, 4'd4, 1'b1);
        check_output("rst_load", 1'b0, 0, 1'b0, 1'b1);
        apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0);
        apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0);
        check_output("rst_pre", 1'b0, 0, 1'b0, 1'b1);
        apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0);
        check_output("rst_mid", 1'b0, 0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'h0B, 4'd4, 1'b1);
        check_output("rst_unarmed", 1'b0, 0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h0B, 4'd4, 1'b1);
        check_output("rst_reload", 1'b0, 0, 1'b0, 1'b1);
        apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0);
        check_output("rst_last", 1'b0, 0, 1'b0, 1'b1);

        // Load with valid data in the same cycle drops that bit; cfg inputs without load are ignored
        apply_stimulus(1'b0, 1'b1, 1'b1, 1'b1, 8'h03, 4'd2, 1'b1);
        check_output("lw_load", 1'b0, 0, 1'b0, 1'b1);
        apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'h01, 4'd1, 1'b0);
        check_output("lw_b1", 1'b0, 0, 1'b0, 1'b1);
        apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 4'd1, 1'b0);
        check_output("lw_b2", 1'b1, 1, 1'b0, 1'b1);
        apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 4'd1, 1'b0);
        check_output("lw_b3", 1'b1, 2, 1'b0, 1'b1);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0);
        check_output("lw_b4", 1'b0, 2, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pattern_seq_detector.md
# pattern_seq_detector

Parametrised serial pattern detector, successor to the fixed four-ones detector. Matches a runtime-programmable bit pattern of 1..MAX_LEN bits on a qualified serial input and pulses `match` on each hit. Supports overlapping or non-overlapping detection and keeps a saturating match counter. Sits on the serial receive path in front of the framing logic.

## Interface
- `MAX_LEN`, 8: maximum pattern length in bits, ≥ 2.
- `LEN_W`, `$clog2(MAX_LEN+1)`: width of `cfg_len`.
- `CNT_W`, 16: width of `match_count`.

Ports:
- `clk`  in  1  sole clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high; one clock, synchronous active-high reset.
- `data_in`  in  1  serial data bit.
- `data_valid`  in  1  `data_in` is sampled only when high.
- `cfg_load`  in  1  one-cycle strobe; latch `cfg_pattern`, `cfg_len` and `cfg_overlap`.
- `cfg_pattern`  in  MAX_LEN  pattern; bit `[cfg_len-1]` is received first, bit `[0]` last.
- `cfg_len`  in  LEN_W  pattern length; legal range 1..MAX_LEN.
- `cfg_overlap`  in  1  1 = overlapping matches allowed; 0 = matching restarts after a hit.
- `match`  out  1  registered one-cycle pulse per detected pattern.
- `match_count`  out  CNT_W  saturating count of matches since reset or load.
- `cfg_err`  out  1  one-cycle pulse when a load is rejected.
- `armed`  out  1  a valid configuration is held.

## Operation
- **States:**
  - UNCONFIG: entered on reset. `armed` = 0, input ignored, `match` never asserted.
  - HUNT: entered from any state on a legal `cfg_load`.
- **Legal load** (`cfg_len` in 1..MAX_LEN):
  - Latch all configuration inputs.
  - Clear the history register, fill counter and `match_count`.
  - Go to HUNT.
- **Illegal load** (`cfg_len` = 0 or > MAX_LEN):
  - Configuration, state, history, fill counter and counter are unchanged.
  - `cfg_err` pulses.
- **In HUNT, on each `data_valid`:**
  - History shifts: `hist <= {hist[MAX_LEN-2:0], data_in}`.
  - Fill counter increments, saturating at MAX_LEN.
  - `data_valid` = 0 holds all state (gaps are transparent).
- **Hit** when fill (after the increment) ≥ `len` and `hist_next[len-1:0] == pattern[len-1:0]`. On a hit:
  - `match` = 1 on the next cycle.
  - `match_count` increments, holding at all-ones.
  - If `overlap` = 0, fill is cleared to 0. History is kept but needs `len` fresh bits before the next hit.
  - If `overlap` = 1, fill is untouched.
- **`cfg_load` together with `data_valid`:** the load wins and that data bit is discarded.
- Only `cfg_load` changes configuration; `cfg_*` inputs are ignored otherwise.

## Timing
- **Reset values:** `match` = 0, `match_count` = 0, `cfg_err` = 0, `armed` = 0, state UNCONFIG, history = 0, fill = 0.
- **`reset` mid-stream:** all of the above on the next edge. Any `match` pending from the reset-cycle bit is dropped.
- **Match latency:** `match` is high in the cycle after the edge that samples the last pattern bit, for exactly 1 cycle.
- `match_count` updates in the same cycle as `match`.
- Back-to-back hits (overlap, e.g. `len` = 1) give consecutive `match` pulses.
- `cfg_err` is high in the cycle after the rejected load.
- `armed` rises in the cycle after a legal load.

## Configuration
- **`SEQDET_COUNT_EN`:**
  - Defined: `match_count` is implemented as specified.
  - Undefined: no counter register; `match_count` is tied to 0.
  - `match`, `cfg_err` and `armed` are unaffected either way.

## Test plan
- Load pattern=4'b1011, len=4, overlap=1. Stream 1,0,1,1,0,1,1 with `data_valid` high → `match` pulses after bit 4 and bit 7; `match_count` = 2.
- Same stream with overlap=0 → single `match` after bit 4; `match_count` = 1.
- Load pattern=4'b1111, len=4, overlap=0. Stream of 8 ones with `data_valid` low every other cycle → `match` after the 4th and 8th valid ones only; gaps cause no extra pulses.
- Load with len=0, then len=MAX_LEN+1 → `cfg_err` pulses twice; `armed` and prior configuration unchanged; subsequent matching uses the old pattern.
- With `CNT_W`=2 and pattern=1'b1, len=1, overlap=1, feed 5 ones → 5 `match` pulses; `match_count` sticks at 3.
- Assert `reset` after 3 of 4 pattern bits, then load again and send the last bit → no `match`; `armed` = 0 after reset until the reload.
